// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit synchroniser, bounce qualification counter,
// registered rise/fall pulses and a sticky change flag for the switch PIO.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             change_pending,
  input  logic             change_clear
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_c;
  logic [WIDTH-1:0]                  edge_c;

  // Synchroniser shift chain; stage 0 samples the raw pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stab_q, stab_d;
    logic             rise_q, fall_q;

    // Qualification: a mismatch must survive DEBOUNCE_CYCLES samples in a row
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stab_d  = stab_q;
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (sync_c[i] != stab_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              stab_d = sync_c[i];
            end else begin
              state_d = ST_QUALIFY;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (sync_c[i] == stab_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            stab_d  = sync_c[i];
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        stab_q  <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        stab_q  <= stab_d;
        rise_q  <= stab_d & ~stab_q;
        fall_q  <= ~stab_d & stab_q;
      end
    end

    assign sw_stable[i] = stab_q;
    assign sw_rise[i]   = rise_q;
    assign sw_fall[i]   = fall_q;
    assign edge_c[i]    = rise_q | fall_q;
  end

  // Sticky change flag; a new edge beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      change_pending <= 1'b0;
    end else if (|edge_c) begin
      change_pending <= 1'b1;
    end else if (change_clear) begin
      change_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: main instance with an 8-cycle filter and
// a second instance with a 1-cycle filter.
module tb_switch_debouncer;

  logic       clk;
  logic       reset;
  logic [9:0] sw_raw, sw_stable, sw_rise, sw_fall;
  logic       change_pending, change_clear;
  logic [9:0] sw_raw1, sw_stable1, sw_rise1, sw_fall1;
  logic       change_pending1, change_clear1;

  int n_checks = 0;
  int n_pass   = 0;
  int rise_cnt = 0;
  int bad      = 0;

  switch_debouncer #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .change_pending(change_pending),
    .change_clear(change_clear)
  );

  switch_debouncer #(.WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .sw_raw(sw_raw1), .sw_stable(sw_stable1),
    .sw_rise(sw_rise1), .sw_fall(sw_fall1), .change_pending(change_pending1),
    .change_clear(change_clear1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Advance while sw_stable must hold; count bit-0 rise pulses seen
  task automatic mon(input int n, input logic [9:0] exp);
    repeat (n) begin
      tick();
      if (sw_stable !== exp) bad++;
      if (sw_rise[0]) rise_cnt++;
    end
  endtask

  task automatic clear_pending();
    change_clear = 1'b1;
    tick();
    change_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sw_raw = '0; change_clear = 1'b0;
    sw_raw1 = '0; change_clear1 = 1'b0;
    ticks(3);
    check("rst_stable", sw_stable, 0);
    check("rst_rise", sw_rise, 0);
    check("rst_pending", change_pending, 0);
    check("rst_stable1", sw_stable1, 0);
    reset = 1'b0;
    ticks(5);
    check("idle_stable", sw_stable, 0);

    // Asynchronous reset with all pins high, then re-qualification
    sw_raw = 10'h3FF;
    ticks(12);
    check("pre_rst_stable", sw_stable, 10'h3FF);
    check("pre_rst_pending", change_pending, 1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_stable", sw_stable, 0);
    check("async_rst_pending", change_pending, 0);
    tick();
    reset = 1'b0;
    ticks(9);
    check("rq_early", sw_stable, 0);
    tick();
    check("rq_stable", sw_stable, 10'h3FF);
    check("rq_rise", sw_rise, 10'h3FF);
    check("rq_pend_lag", change_pending, 0);
    tick();
    check("rq_rise_off", sw_rise, 0);
    check("rq_pending", change_pending, 1);
    clear_pending();
    check("clr_pending", change_pending, 0);

    // All bits fall back to zero
    sw_raw = '0;
    ticks(10);
    check("all_fall", sw_fall, 10'h3FF);
    check("all_fall_stable", sw_stable, 0);
    tick();
    clear_pending();

    // Clean step on bit 3
    sw_raw = 10'h008;
    ticks(9);
    check("step_early", sw_stable, 0);
    tick();
    check("step_stable", sw_stable, 10'h008);
    check("step_rise", sw_rise, 10'h008);
    check("step_fall", sw_fall, 0);
    tick();
    check("step_rise_off", sw_rise, 0);

    // Bounce on bit 0: 5 high, 1 low, twenty times, then settle high
    rise_cnt = 0; bad = 0;
    for (int r = 0; r < 20; r++) begin
      sw_raw[0] = 1'b1; mon(5, 10'h008);
      sw_raw[0] = 1'b0; mon(1, 10'h008);
    end
    sw_raw[0] = 1'b1;
    mon(9, 10'h008);
    mon(1, 10'h009);
    check("bounce_rise", sw_rise, 10'h001);
    mon(3, 10'h009);
    check("bounce_hold", bad, 0);
    check("bounce_rise_cnt", rise_cnt, 1);
    clear_pending();

    // Bits 1 and 9 fall together; clear collides with set
    sw_raw = 10'h20B;
    ticks(12);
    check("sim_pre", sw_stable, 10'h20B);
    clear_pending();
    check("sim_pend0", change_pending, 0);
    sw_raw = 10'h009;
    ticks(10);
    check("sim_fall", sw_fall, 10'h202);
    check("sim_rise", sw_rise, 0);
    check("sim_stable", sw_stable, 10'h009);
    change_clear = 1'b1;
    tick();
    check("sim_set_wins", change_pending, 1);
    tick();
    check("sim_clear", change_pending, 0);
    change_clear = 1'b0;

    // Reset during bit-5 qualification
    sw_raw = 10'h029;
    ticks(8);
    check("midq_stable", sw_stable, 10'h009);
    check("midq_rise", sw_rise, 0);
    reset = 1'b1;
    tick();
    check("midq_rst", sw_stable, 0);
    reset = 1'b0;
    ticks(9);
    check("midq_early", sw_stable, 0);
    tick();
    check("midq_stable2", sw_stable, 10'h029);
    check("midq_rise2", sw_rise, 10'h029);

    // Single-cycle filter instance
    sw_raw1 = 10'h004;
    ticks(2);
    check("dc1_early", sw_stable1, 0);
    tick();
    check("dc1_stable", sw_stable1, 10'h004);
    check("dc1_rise", sw_rise1, 10'h004);
    tick();
    sw_raw1 = 10'h084;
    tick();
    sw_raw1 = 10'h004;
    ticks(2);
    check("dc1_glitch_rise", sw_rise1, 10'h080);
    check("dc1_glitch_stable", sw_stable1, 10'h084);
    tick();
    check("dc1_glitch_fall", sw_fall1, 10'h080);
    check("dc1_glitch_rise_off", sw_rise1, 0);
    check("dc1_final", sw_stable1, 10'h004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
